// File: rtl/decode_stage_if.sv
// D/E pipeline register bundle carried from the decode stage to execute.
interface decode_stage_if;
  logic [31:0] E_PC;
  logic [31:0] E_Ins;
  logic        E_DS;
  logic [4:0]  E_ExcCode;
  logic [31:0] E_rs_val;
  logic [31:0] E_rt_val;
  logic [31:0] E_imm32;

  modport master (
    output E_PC, E_Ins, E_DS, E_ExcCode, E_rs_val, E_rt_val, E_imm32
  );

  modport slave (
    input E_PC, E_Ins, E_DS, E_ExcCode, E_rs_val, E_rt_val, E_imm32
  );
endinterface

// File: rtl/decode_stage.sv
// MIPS decode stage: instruction decode, branch/jump resolution, exception
// detection and the D/E pipeline register.
module decode_stage #(
  parameter logic [4:0] EXC_RI      = 5'd10,
  parameter logic [4:0] EXC_SYSCALL = 5'd8,
  parameter logic [4:0] EXC_NONE    = 5'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic [31:0] EBase,
  input  logic [31:0] EPC,
  input  logic        D_Stall,
  input  logic [31:0] F_PC,
  input  logic [31:0] D_PC,
  input  logic [31:0] D_Ins,
  input  logic        D_DS,
  input  logic [4:0]  D_ExcCode_in,
  input  logic [31:0] D_rs_val,
  input  logic [31:0] D_rt_val,
  output logic [4:0]  D_rs_addr,
  output logic [4:0]  D_rt_addr,
  output logic [31:0] NPC,
  output logic [2:0]  NPCSelect,
  output logic        D_Flush,
  output logic        D_eret,
  decode_stage_if.master de
);

  typedef enum logic [1:0] {EXT_SIGN, EXT_ZERO, EXT_LUI} ext_e;

  localparam logic [31:0] ERET_WORD = 32'h4200_0018;

  logic [5:0]  op, funct;
  logic [15:0] imm16;
  logic        legal, is_sys;
  ext_e        ext;
  logic [31:0] imm_sext, imm32, br_target;
  logic        br_taken;
  logic [4:0]  exc_merged;

  logic [31:0] e_pc_d, e_ins_d, e_rs_d, e_rt_d, e_imm_d;
  logic [31:0] e_pc_q, e_ins_q, e_rs_q, e_rt_q, e_imm_q;
  logic        e_ds_d, e_ds_q;
  logic [4:0]  e_exc_d, e_exc_q;

  assign op        = D_Ins[31:26];
  assign funct     = D_Ins[5:0];
  assign imm16     = D_Ins[15:0];
  assign D_rs_addr = D_Ins[25:21];
  assign D_rt_addr = D_Ins[20:16];

  always_comb begin
    legal     = 1'b0;
    is_sys    = 1'b0;
    ext       = EXT_SIGN;
    NPCSelect = 3'd0;
    case (op)
      6'h00: begin
        case (funct)
          6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h2b,
          6'h18, 6'h19, 6'h1a, 6'h1b,
          6'h10, 6'h11, 6'h12, 6'h13: legal = 1'b1;
          6'h08, 6'h09: begin
            legal     = 1'b1;
            NPCSelect = 3'd3;
          end
          6'h0c: begin
            legal  = 1'b1;
            is_sys = 1'b1;
          end
          6'h00:   legal = (D_Ins == '0);
          default: legal = 1'b0;
        endcase
      end
      6'h0f: begin
        legal = 1'b1;
        ext   = EXT_LUI;
      end
      6'h0c, 6'h0d: begin
        legal = 1'b1;
        ext   = EXT_ZERO;
      end
      6'h08, 6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2b: legal = 1'b1;
      6'h04, 6'h05: begin
        legal     = 1'b1;
        NPCSelect = 3'd1;
      end
      6'h02, 6'h03: begin
        legal     = 1'b1;
        NPCSelect = 3'd2;
      end
      6'h10: begin
        if (D_Ins == ERET_WORD) begin
          legal     = 1'b1;
          NPCSelect = 3'd4;
        end else begin
          legal = (D_rs_addr == 5'd0) || (D_rs_addr == 5'd4);
        end
      end
      default: legal = 1'b0;
    endcase
  end

  assign imm_sext = {{16{imm16[15]}}, imm16};

  always_comb begin
    case (ext)
      EXT_ZERO: imm32 = {16'h0000, imm16};
      EXT_LUI:  imm32 = {imm16, 16'h0000};
      default:  imm32 = imm_sext;
    endcase
  end

  assign br_taken  = (op == 6'h04) ? (D_rs_val == D_rt_val) : (D_rs_val != D_rt_val);
  assign br_target = D_PC + 32'd4 + {imm_sext[29:0], 2'b00};

  // Req redirects fetch to the handler whatever the D instruction is.
  always_comb begin
    NPC = F_PC + 32'd4;
    if (Req) begin
      NPC = EBase;
    end else begin
      case (NPCSelect)
        3'd1:    NPC = br_taken ? br_target : F_PC + 32'd4;
        3'd2:    NPC = {D_PC[31:28], D_Ins[25:0], 2'b00};
        3'd3:    NPC = D_rs_val;
        3'd4:    NPC = EPC;
        default: NPC = F_PC + 32'd4;
      endcase
    end
  end

  assign D_eret  = (D_Ins == ERET_WORD);
  assign D_Flush = D_eret;

  always_comb begin
    if (D_ExcCode_in != EXC_NONE) exc_merged = D_ExcCode_in;
    else if (!legal)              exc_merged = EXC_RI;
    else if (is_sys)              exc_merged = EXC_SYSCALL;
    else                          exc_merged = EXC_NONE;
  end

  // A stall bubble still carries PC/DS so a later-stage EPC stays correct.
  always_comb begin
    e_pc_d  = '0;
    e_ins_d = '0;
    e_ds_d  = 1'b0;
    e_exc_d = '0;
    e_rs_d  = '0;
    e_rt_d  = '0;
    e_imm_d = '0;
    if (Req) begin
      e_pc_d = EBase;
    end else if (D_Stall) begin
      e_pc_d = D_PC;
      e_ds_d = D_DS;
    end else begin
      e_pc_d  = D_PC;
      e_ins_d = D_Ins;
      e_ds_d  = D_DS;
      e_exc_d = exc_merged;
      e_rs_d  = D_rs_val;
      e_rt_d  = D_rt_val;
      e_imm_d = imm32;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_pc_q  <= '0;
      e_ins_q <= '0;
      e_ds_q  <= 1'b0;
      e_exc_q <= '0;
      e_rs_q  <= '0;
      e_rt_q  <= '0;
      e_imm_q <= '0;
    end else begin
      e_pc_q  <= e_pc_d;
      e_ins_q <= e_ins_d;
      e_ds_q  <= e_ds_d;
      e_exc_q <= e_exc_d;
      e_rs_q  <= e_rs_d;
      e_rt_q  <= e_rt_d;
      e_imm_q <= e_imm_d;
    end
  end

  assign de.E_PC      = e_pc_q;
  assign de.E_Ins     = e_ins_q;
  assign de.E_DS      = e_ds_q;
  assign de.E_ExcCode = e_exc_q;
  assign de.E_rs_val  = e_rs_q;
  assign de.E_rt_val  = e_rt_q;
  assign de.E_imm32   = e_imm_q;

endmodule
